// File: rtl/add_arb_pkg.sv
// Shared constants for the round-robin arbitrated split-carry adder.
package add_arb_pkg;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned W       = 8;
  localparam int unsigned ID_W    = $clog2(NREQ);
  localparam int unsigned HALF_W  = W / 2;
  localparam int unsigned ADD_LAT = 2;

  // Id width that stays legal for a single requester.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_split_pipe.sv
// Two-stage adder: low half plus carry-in first, high half plus low carry second.
module add_split_pipe #(
  parameter int unsigned W    = add_arb_pkg::W,
  parameter int unsigned ID_W = add_arb_pkg::ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            cin,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  output logic [W-1:0]    sum,
  output logic            cout,
  output logic [ID_W-1:0] out_id
);

  localparam int unsigned HW = W / 2;

  logic            s1_valid;
  logic [HW-1:0]   s1_lo;
  logic            s1_c;
  logic [HW-1:0]   s1_a_hi;
  logic [HW-1:0]   s1_b_hi;
  logic [ID_W-1:0] s1_id;

  logic [HW:0]     lo_c;
  logic [HW:0]     hi_c;

  assign lo_c = {1'b0, a[HW-1:0]} + {1'b0, b[HW-1:0]} + {{HW{1'b0}}, cin};
  assign hi_c = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {{HW{1'b0}}, s1_c};

  // Stage 1: low-half sum and carry, high operands and id carried forward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
      s1_id    <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo   <= lo_c[HW-1:0];
        s1_c    <= lo_c[HW];
        s1_a_hi <= a[W-1:HW];
        s1_b_hi <= b[W-1:HW];
        s1_id   <= in_id;
      end
    end
  end

  // Stage 2: result registers hold their last value between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      out_id    <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        {cout, sum} <= {hi_c, s1_lo};
        out_id      <= s1_id;
      end
    end
  end

endmodule

// File: rtl/add_arb4.sv
// Round-robin arbiter sharing one pipelined adder among NREQ requesters,
// with one operation in flight per requester.
module add_arb4 #(
  parameter int unsigned NREQ = add_arb_pkg::NREQ,
  parameter int unsigned W    = add_arb_pkg::W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    en,
  input  logic [NREQ-1:0]                         req_valid,
  output logic [NREQ-1:0]                         req_ready,
  input  logic [NREQ*W-1:0]                       req_a,
  input  logic [NREQ*W-1:0]                       req_b,
  input  logic [NREQ-1:0]                         req_cin,
  output logic                                    rsp_valid,
  output logic [add_arb_pkg::id_width(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]                            rsp_sum,
  output logic                                    rsp_cout,
  output logic [NREQ-1:0]                         pending
);

  import add_arb_pkg::*;

  localparam int unsigned IDW = id_width(NREQ);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] clr;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_cin;

  assign elig = rst ? '0 : (req_valid & ~pending & {NREQ{en}});

  // First eligible requester at or after ptr, wrapping.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  assign gnt       = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  assign req_ready = gnt;

  assign sel_a   = req_a[32'(gnt_idx) * W +: W];
  assign sel_b   = req_b[32'(gnt_idx) * W +: W];
  assign sel_cin = req_cin[gnt_idx];

  assign clr = rsp_valid ? (NREQ'(1) << rsp_id) : '0;

  // Pointer advance and per-requester in-flight tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      pending <= '0;
    end else begin
      pending <= (pending | gnt) & ~clr;
      if (gnt_any) begin
        ptr <= (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
      end
    end
  end

  add_split_pipe #(
    .W    (W),
    .ID_W (IDW)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (gnt_any),
    .a         (sel_a),
    .b         (sel_b),
    .cin       (sel_cin),
    .in_id     (gnt_idx),
    .out_valid (rsp_valid),
    .sum       (rsp_sum),
    .cout      (rsp_cout),
    .out_id    (rsp_id)
  );

endmodule

// File: doc/add_arb4.md
ADD_ARB4 -- requirements
Module: add_arb4

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the adder.
REQ-002 Parameter W, default 8, operand width; SHALL be even (split into two W/2 halves).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  grant enable; 0 blocks new grants, in-flight operations still complete.
REQ-006 req_valid  input  NREQ  per-requester operation request.
REQ-007 req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_a, req_b  input  NREQ*W each  packed operands; requester i uses bits [i*W +: W].
REQ-009 req_cin  input  NREQ  per-requester carry-in.
REQ-010 rsp_valid  output  1  one-cycle result strobe; no backpressure.
REQ-011 rsp_id  output  log2(NREQ)  index of the requester owning the result.
REQ-012 rsp_sum  output  W  sum bits; rsp_cout  output  1  carry-out.
REQ-013 pending  output  NREQ  requesters with an operation in flight.

Function
REQ-014 Transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-015 Requester i SHALL be eligible when req_valid[i]=1, pending[i]=0 and en=1.
REQ-016 Grant SHALL be round-robin: search eligible requesters starting at pointer ptr, ascending, wrapping at NREQ-1 to 0.
REQ-017 After a grant to i, ptr SHALL become (i+1) mod NREQ; with no grant ptr SHALL hold.
REQ-018 req_ready SHALL be combinational from eligibility and ptr; it SHALL NOT depend on operand values.
REQ-019 Aggregate throughput SHALL be one accepted operation per cycle when any requester is eligible.
REQ-020 The datapath SHALL be two registered stages: stage 1 registers low-half sum {c_lo, s_lo} = a[W/2-1:0]+b[W/2-1:0]+cin, plus the operand high halves and id; stage 2 registers high-half sum a_hi+b_hi+c_lo concatenated with s_lo.
REQ-021 Arithmetic SHALL be unsigned: {rsp_cout, rsp_sum} = a + b + cin, W+1 bits, no sign extension.
REQ-022 rsp_valid SHALL assert exactly 2 cycles after the transfer cycle (transfer in cycle t -> rsp_valid in cycle t+2), carrying that transfer's id and result.
REQ-023 pending[i] SHALL set at the end of the transfer cycle and clear at the end of the cycle where rsp_valid=1 with rsp_id=i; requester i is thus eligible again no earlier than cycle t+3.
REQ-024 Set and clear of different pending bits in the same cycle SHALL both take effect.
REQ-025 en falling mid-stream SHALL NOT cancel or alter in-flight operations; they complete per REQ-022.
REQ-026 When rsp_valid=0, rsp_id, rsp_sum, rsp_cout SHALL hold their last values.
REQ-027 Inputs of non-granted requesters SHALL have no effect on any output or state.

Reset
REQ-028 rst=1 SHALL immediately force: req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, pending=0, ptr=0, both stage valid bits=0.
REQ-029 Operations in flight when rst asserts SHALL be discarded with no rsp_valid after release.
REQ-030 First grant after rst deasserts SHALL be no earlier than the first rising clk edge with rst=0.

Structure
REQ-031 Package add_arb_pkg SHALL hold NREQ, W, ID_W=$clog2(NREQ), HALF_W=W/2 defaults and the pipeline latency constant ADD_LAT=2.
REQ-032 The two-stage split adder SHALL be a sub-module add_split_pipe (operands, cin, id, in-valid -> sum, cout, id, out-valid); arbitration, ptr and pending live in add_arb4.

Verification
REQ-033 Single requester: req_valid[2]=1, a=0x0F, b=0x01, cin=0 in cycle 0 -> req_ready[2]=1 cycle 0; rsp_valid cycle 2, rsp_id=2, rsp_sum=0x10, rsp_cout=0 (low-to-high carry).
REQ-034 Overflow: a=0xFF, b=0xFF, cin=1 -> rsp_sum=0xFF, rsp_cout=1; a=0x80, b=0x80, cin=0 -> rsp_sum=0x00, rsp_cout=1 (unsigned).
REQ-035 Round-robin: all four req_valid held high from reset -> grants 0,1,2,3 in cycles 0-3, rsp_id 0,1,2,3 in cycles 2-5, then requester 0 granted again cycle 4 (ptr wrap).
REQ-036 Pending rule: only requester 1 valid continuously -> grants at cycles 0,3,6; req_ready[1]=0 in cycles 1,2,4,5.
REQ-037 en/reset: en=0 after grant in cycle 0 -> no grants cycle 1 on, result still appears cycle 2; separately rst pulse in cycle 1 after a cycle-0 grant -> no rsp_valid ever, pending=0, ptr=0.
